// File: rtl/cpu_local_bus.sv
// cpu_local_bus: per-CPU AHB-lite local interconnect.
// Decodes 4 KB slave windows from HADDR[15:12] and muxes the data-phase response.
// A default slave answers unmapped windows with a two-cycle ERROR.
// A watchdog ends a stalled slave data phase with the same ERROR sequence.

package cpu_local_bus_pkg;
    typedef struct packed {
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic        hwrite;
        logic [31:0] hwdata;
    } AhbC;

    typedef struct packed {
        logic [31:0] hrdata;
        logic        hready;
    } AhbR;
endpackage

module cpu_local_bus
    import cpu_local_bus_pkg::*;
#(
    parameter int unsigned NSLV    = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m_hsel,
    input  AhbC             m_ahbc,
    output AhbR             m_ahbr,
    output logic            m_hresp,
    output logic [NSLV-1:0] s_hsel,
    output AhbC             s_ahbc,
    input  AhbR             s_ahbr [NSLV],
    output logic            timeout_o
);

    localparam int unsigned   WW   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TMAX = WW'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_SLV, ST_ERR1, ST_ERR2} state_t;

    state_t        state, state_nxt, cur;
    logic [3:0]    slv_q, slv_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic [3:0]    idx;
    logic          mapped;
    logic          fire;
    logic          addr_valid;
    logic          hready_int;
    logic [31:0]   hrdata_int;
    AhbR           sel;

    assign s_ahbc = m_ahbc;
    assign idx    = m_ahbc.haddr[15:12];
    assign mapped = {1'b0, idx} < 5'(NSLV);
    assign m_ahbr = {hrdata_int, hready_int};

    // Reset forces the idle response in the same cycle, not only after the edge.
    assign cur  = rst ? ST_IDLE : state;
    // A cycle that starts stalled at the limit behaves as ERR1.
    assign fire = (TIMEOUT != 0) && (cur == ST_SLV) && (wcnt == TMAX);

    // Select the response of the slave owning the current data phase.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (slv_q == 4'(i)) sel = s_ahbr[i];
        end
    end

    // State register: data-phase kind, owning slave and watchdog count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            slv_q <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            slv_q <= slv_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next state: a new address phase is taken whenever the bus is ready.
    always_comb begin
        state_nxt = state;
        slv_nxt   = slv_q;
        wcnt_nxt  = wcnt;
        if (hready_int) begin
            slv_nxt  = idx;
            wcnt_nxt = '0;
            if (addr_valid) state_nxt = mapped ? ST_SLV : ST_ERR1;
            else            state_nxt = ST_IDLE;
        end
        case (cur)
            ST_SLV: begin
                if (fire) begin
                    state_nxt = ST_ERR2;
                    wcnt_nxt  = '0;
                end else if (!hready_int && wcnt != TMAX) begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            ST_ERR1: begin
                state_nxt = ST_ERR2;
                wcnt_nxt  = '0;
            end
            default: ;
        endcase
    end

    // Outputs: response to the master and address-phase slave selects.
    always_comb begin
        hready_int = 1'b1;
        hrdata_int = '0;
        m_hresp    = 1'b0;
        case (cur)
            ST_SLV: begin
                if (fire) begin
                    hready_int = 1'b0;
                    m_hresp    = 1'b1;
                end else begin
                    hready_int = sel.hready;
                    hrdata_int = sel.hrdata;
                end
            end
            ST_ERR1: begin
                hready_int = 1'b0;
                m_hresp    = 1'b1;
            end
            ST_ERR2: m_hresp = 1'b1;
            default: ;
        endcase
        timeout_o  = fire;
        addr_valid = !rst && m_hsel && m_ahbc.htrans[1] && hready_int;
        s_hsel     = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            s_hsel[i] = addr_valid && mapped && (idx == 4'(i));
        end
    end

endmodule

// File: tb/tb_cpu_local_bus.sv
// Directed testbench for cpu_local_bus (NSLV=2, TIMEOUT=16).
// Slave 0 models a local register block (CPUID=3 at 0x0, scratch at 0x4).
// Slave 1 is a programmable wait-state slave.

module tb_cpu_local_bus;
    import cpu_local_bus_pkg::*;

    localparam int unsigned NSLV    = 2;
    localparam int unsigned TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_hsel;
    AhbC        m_ahbc;
    AhbR        m_ahbr;
    logic       m_hresp;
    logic [1:0] s_hsel;
    AhbC        s_ahbc;
    AhbR        s_ahbr [2];
    logic       timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_local_bus #(.NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .m_hsel(m_hsel), .m_ahbc(m_ahbc),
        .m_ahbr(m_ahbr), .m_hresp(m_hresp), .s_hsel(s_hsel),
        .s_ahbc(s_ahbc), .s_ahbr(s_ahbr), .timeout_o(timeout_o)
    );

    // Slave 0: register block
    logic        p0, p0wr;
    logic [11:0] p0a;
    logic [31:0] scratch;
    always @(posedge clk) begin
        if (rst) begin
            p0 <= 1'b0; p0wr <= 1'b0; p0a <= '0; scratch <= '0;
        end else begin
            if (p0 && p0wr && p0a == 12'h004) scratch <= s_ahbc.hwdata;
            p0   <= s_hsel[0];
            p0a  <= s_ahbc.haddr[11:0];
            p0wr <= s_ahbc.hwrite;
        end
    end
    always_comb begin
        s_ahbr[0].hready = 1'b1;
        s_ahbr[0].hrdata = '0;
        if (p0 && !p0wr)
            s_ahbr[0].hrdata = (p0a == 12'h000) ? 32'h3 : (p0a == 12'h004) ? scratch : 32'h0;
    end

    // Slave 1: ready after s1_wait wait states; negative means never ready
    logic p1;
    int   cnt1;
    int   s1_wait = 0;
    logic s1_rdy;
    assign s1_rdy = !p1 || (s1_wait >= 0 && cnt1 >= s1_wait);
    always @(posedge clk) begin
        if (rst) begin
            p1 <= 1'b0; cnt1 <= 0;
        end else if (s_hsel[1]) begin
            p1 <= 1'b1; cnt1 <= 0;
        end else if (p1 && s1_rdy) begin
            p1 <= 1'b0;
        end else if (p1) begin
            cnt1 <= cnt1 + 1;
        end
    end
    always_comb begin
        s_ahbr[1].hready = s1_rdy;
        s_ahbr[1].hrdata = (p1 && s1_rdy) ? 32'hA5A5_0001 : 32'h0;
    end

    // {HREADY, HRESP, timeout_o, s_hsel}
    function automatic logic [4:0] ctl();
        return {m_ahbr.hready, m_hresp, timeout_o, s_hsel};
    endfunction

    task automatic drive(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        m_hsel = 1'b1;
        m_ahbc = '{htrans: 2'b10, haddr: addr, hsize: 3'd2, hwrite: wr, hwdata: wdata};
    endtask

    task automatic idle(input logic [31:0] wdata);
        m_hsel = 1'b0;
        m_ahbc = '{htrans: 2'b00, haddr: 32'h0, hsize: 3'd2, hwrite: 1'b0, hwdata: wdata};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl(), 5'b10000); end
        n_checks++;
        if (m_ahbr.hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h expected %h", m_ahbr.hrdata, 32'h0); end
        step();
        step();
        rst = 1'b0;
        idle(32'h0);
        @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL post_reset_ctl: got %b expected %b", ctl(), 5'b10000); end
    endtask

    task automatic test_read_cpuid();
        step(); drive(32'h0000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10001) begin n_fail++; $display("FAIL cpuid_addr: got %b expected %b", ctl(), 5'b10001); end
        step(); idle(32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL cpuid_data_ctl: got %b expected %b", ctl(), 5'b10000); end
        n_checks++;
        if (m_ahbr.hrdata !== 32'h3) begin n_fail++; $display("FAIL cpuid_data: got %h expected %h", m_ahbr.hrdata, 32'h3); end
    endtask

    task automatic test_back_to_back();
        s1_wait = 0;
        step(); drive(32'h0004, 1'b1, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10001) begin n_fail++; $display("FAIL b2b_wr_addr: got %b expected %b", ctl(), 5'b10001); end
        step(); drive(32'h0004, 1'b0, 32'h1234_5678); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10001) begin n_fail++; $display("FAIL b2b_wr_data: got %b expected %b", ctl(), 5'b10001); end
        step(); drive(32'h1000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10010) begin n_fail++; $display("FAIL b2b_rd_data_ctl: got %b expected %b", ctl(), 5'b10010); end
        n_checks++;
        if (m_ahbr.hrdata !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_rd_data: got %h expected %h", m_ahbr.hrdata, 32'h1234_5678); end
        step(); drive(32'h0000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10001) begin n_fail++; $display("FAIL b2b_s1_ctl: got %b expected %b", ctl(), 5'b10001); end
        n_checks++;
        if (m_ahbr.hrdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_s1_data: got %h expected %h", m_ahbr.hrdata, 32'hA5A5_0001); end
        step(); idle(32'h0); @(negedge clk);
        n_checks++;
        if (m_ahbr.hrdata !== 32'h3) begin n_fail++; $display("FAIL b2b_s0_data: got %h expected %h", m_ahbr.hrdata, 32'h3); end
    endtask

    task automatic test_unmapped();
        step(); drive(32'h7000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL unmapped_addr: got %b expected %b", ctl(), 5'b10000); end
        step(); drive(32'h0000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b01000) begin n_fail++; $display("FAIL unmapped_err1: got %b expected %b", ctl(), 5'b01000); end
        n_checks++;
        if (m_ahbr.hrdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_err1_data: got %h expected %h", m_ahbr.hrdata, 32'h0); end
        step(); drive(32'h0000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b11001) begin n_fail++; $display("FAIL unmapped_err2: got %b expected %b", ctl(), 5'b11001); end
        n_checks++;
        if (m_ahbr.hrdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_err2_data: got %h expected %h", m_ahbr.hrdata, 32'h0); end
        step(); idle(32'h0); @(negedge clk);
        n_checks++;
        if ({ctl(), m_ahbr.hrdata} !== {5'b10000, 32'h3}) begin n_fail++; $display("FAIL unmapped_next: got %b/%h expected %b/%h", ctl(), m_ahbr.hrdata, 5'b10000, 32'h3); end
    endtask

    task automatic test_timeout();
        s1_wait = -1;
        step(); drive(32'h1000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10010) begin n_fail++; $display("FAIL to_addr: got %b expected %b", ctl(), 5'b10010); end
        for (int c = 1; c <= 16; c++) begin
            step(); idle(32'h0); @(negedge clk);
            n_checks++;
            if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL to_stall_%0d: got %b expected %b", c, ctl(), 5'b00000); end
        end
        step(); idle(32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b01100) begin n_fail++; $display("FAIL to_err1: got %b expected %b", ctl(), 5'b01100); end
        step(); drive(32'h0000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b11001) begin n_fail++; $display("FAIL to_err2: got %b expected %b", ctl(), 5'b11001); end
        step(); idle(32'h0); @(negedge clk);
        n_checks++;
        if ({ctl(), m_ahbr.hrdata} !== {5'b10000, 32'h3}) begin n_fail++; $display("FAIL to_next: got %b/%h expected %b/%h", ctl(), m_ahbr.hrdata, 5'b10000, 32'h3); end
    endtask

    task automatic test_ready_at_limit();
        s1_wait = 15;
        step(); drive(32'h1000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10010) begin n_fail++; $display("FAIL lim_addr: got %b expected %b", ctl(), 5'b10010); end
        for (int c = 1; c <= 15; c++) begin
            step(); idle(32'h0); @(negedge clk);
            n_checks++;
            if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL lim_stall_%0d: got %b expected %b", c, ctl(), 5'b00000); end
        end
        step(); idle(32'h0); @(negedge clk);
        n_checks++;
        if ({ctl(), m_ahbr.hrdata} !== {5'b10000, 32'hA5A5_0001}) begin n_fail++; $display("FAIL lim_done: got %b/%h expected %b/%h", ctl(), m_ahbr.hrdata, 5'b10000, 32'hA5A5_0001); end
        step(); idle(32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL lim_after: got %b expected %b", ctl(), 5'b10000); end
    endtask

    task automatic test_reset_in_err1();
        step(); drive(32'h7000, 1'b0, 32'h0); @(negedge clk);
        step(); rst = 1'b1; idle(32'h0); @(negedge clk);
        n_checks++;
        if ({ctl(), m_ahbr.hrdata} !== {5'b10000, 32'h0}) begin n_fail++; $display("FAIL rst_err1_during: got %b/%h expected %b/%h", ctl(), m_ahbr.hrdata, 5'b10000, 32'h0); end
        step(); rst = 1'b0; idle(32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL rst_err1_after: got %b expected %b", ctl(), 5'b10000); end
        step(); drive(32'h0000, 1'b0, 32'h0); @(negedge clk);
        n_checks++;
        if (ctl() !== 5'b10001) begin n_fail++; $display("FAIL rst_err1_addr: got %b expected %b", ctl(), 5'b10001); end
        step(); idle(32'h0); @(negedge clk);
        n_checks++;
        if ({ctl(), m_ahbr.hrdata} !== {5'b10000, 32'h3}) begin n_fail++; $display("FAIL rst_err1_read: got %b/%h expected %b/%h", ctl(), m_ahbr.hrdata, 5'b10000, 32'h3); end
    endtask

    initial begin
        test_reset();
        test_read_cpuid();
        test_back_to_back();
        test_unmapped();
        test_timeout();
        test_ready_at_limit();
        test_reset_in_err1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
